// File: rtl/comp_acc_pkg.sv
// Shared definitions for the complex accumulator: FSM encoding and the
// accumulator width rule, so the bench can size its model identically.
package comp_acc_pkg;

    typedef enum logic {
        ACC = 1'b0,
        OUT = 1'b1
    } state_t;

    // Accumulator width: product width plus log2 of the frame length, so a
    // full frame of most-negative products can never overflow.
    function automatic int calc_aw(input int dwidth, input int log2_len);
        return 2 * (dwidth + 1) + log2_len;
    endfunction

endpackage

// File: rtl/comp_acc.sv
// Complex accumulator: sums up to 2**LOG2_LEN complex samples {xr,yr} per
// frame and presents the full-width sum with a sample count over a
// valid/ready output port.
//
// state | meaning
// ------+---------------------------------------------------------------
// ACC   | accepting samples; in_rdy=1, out_val=0
// OUT   | result presented; in_rdy=0, out_val=1, held until out_rdy
module comp_acc
    import comp_acc_pkg::*;
#(
    parameter int DWIDTH   = 8,
    parameter int LOG2_LEN = 2
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         sw_rst,
    input  logic                                         in_val,
    output logic                                         in_rdy,
    input  logic [4*(DWIDTH+1)-1:0]                      in_data,
    input  logic                                         in_last,
    output logic                                         out_val,
    input  logic                                         out_rdy,
    output logic [2*calc_aw(DWIDTH, LOG2_LEN)-1:0]       out_data,
    output logic [LOG2_LEN:0]                            out_cnt
);

    localparam int PW = 2 * (DWIDTH + 1);
    localparam int AW = calc_aw(DWIDTH, LOG2_LEN);
    localparam int CW = LOG2_LEN + 1;
    localparam int N  = 2 ** LOG2_LEN;
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    state_t                r_state;
    state_t                w_next;
    logic [CW-1:0]         r_cnt;
    logic signed [AW-1:0]  r_xa;
    logic signed [AW-1:0]  r_ya;

    logic signed [PW-1:0]  w_xr;
    logic signed [PW-1:0]  w_yr;
    logic signed [AW-1:0]  w_xr_ext;
    logic signed [AW-1:0]  w_yr_ext;
    logic                  w_in_acc;
    logic                  w_out_hs;
    logic                  w_frame_end;

    assign w_xr     = in_data[2*PW-1:PW];
    assign w_yr     = in_data[PW-1:0];
    assign w_xr_ext = AW'(w_xr);
    assign w_yr_ext = AW'(w_yr);

    // Handshakes derive only from the registered state, so there is no
    // combinational path from in_val/out_rdy back to in_rdy/out_val.
    assign in_rdy      = (r_state == ACC);
    assign out_val     = (r_state == OUT);
    assign w_in_acc    = in_val & in_rdy;
    assign w_out_hs    = out_val & out_rdy;
    // A sample carrying in_last on the final slot is still a single end.
    assign w_frame_end = w_in_acc & ((r_cnt == LAST_CNT) | in_last);

    assign out_data = {r_xa, r_ya};
    assign out_cnt  = r_cnt;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ACC;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; sw_rst overrides both frame end and handshake.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ACC: if (w_frame_end) w_next = OUT;
            OUT: if (out_rdy)     w_next = ACC;
            default:              w_next = ACC;
        endcase
        if (sw_rst) w_next = ACC;
    end

    // Accumulator and sample counter: load on first sample, add afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_xa  <= '0;
            r_ya  <= '0;
        end else if (sw_rst) begin
            r_cnt <= '0;
            r_xa  <= '0;
            r_ya  <= '0;
        end else if (w_in_acc) begin
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == '0) begin
                r_xa <= w_xr_ext;
                r_ya <= w_yr_ext;
            end else begin
                r_xa <= r_xa + w_xr_ext;
                r_ya <= r_ya + w_yr_ext;
            end
        end else if (w_out_hs) begin
            r_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_comp_acc.sv
// Directed bench for comp_acc with a scoreboard: sequences push hand-computed
// results into a queue, a monitor pops and compares on each output handshake.
module tb_comp_acc;
    import comp_acc_pkg::*;

    localparam int DW = 8;
    localparam int LL = 2;
    localparam int PW = 2 * (DW + 1);
    localparam int AW = calc_aw(DW, LL);

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                sw_rst = 1'b0;
    logic                in_val = 1'b0;
    logic                in_rdy;
    logic [2*PW-1:0]     in_data = '0;
    logic                in_last = 1'b0;
    logic                out_val;
    logic                out_rdy = 1'b0;
    logic [2*AW-1:0]     out_data;
    logic [LL:0]         out_cnt;

    int n_vec = 0;
    int n_err = 0;
    logic [2*AW+LL:0] exp_q[$];

    comp_acc #(.DWIDTH(DW), .LOG2_LEN(LL)) dut (
        .clk(clk), .rst(rst), .sw_rst(sw_rst),
        .in_val(in_val), .in_rdy(in_rdy), .in_data(in_data), .in_last(in_last),
        .out_val(out_val), .out_rdy(out_rdy), .out_data(out_data), .out_cnt(out_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [2*AW-1:0] pack(input int x, input int y);
        return {AW'(x), AW'(y)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int x, input int y, input int c);
        exp_q.push_back({pack(x, y), 3'(c)});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one sample and hold it until the edge that accepts it.
    task automatic send(input int xr, input int yr, input bit last);
        int guard;
        in_val  = 1'b1;
        in_data = {PW'(xr), PW'(yr)};
        in_last = last;
        guard   = 0;
        while (!in_rdy && guard < 50) begin
            tick();
            guard++;
        end
        if (!in_rdy) chk("send_timeout", 64'(in_rdy), 64'd1);
        tick();
        in_val  = 1'b0;
        in_last = 1'b0;
    endtask

    // Monitor: compare every output transfer against the scoreboard.
    initial begin
        logic [2*AW+LL:0] e;
        forever begin
            @(negedge clk);
            if (out_val && out_rdy && !rst) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 64'(out_data), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("result_data", 64'(out_data), 64'(e[2*AW+LL:LL+1]));
                    chk("result_cnt",  64'(out_cnt),  64'(e[LL:0]));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        chk("rst_in_rdy",  64'(in_rdy),   64'd1);
        chk("rst_out_val", 64'(out_val),  64'd0);
        chk("rst_out_cnt", 64'(out_cnt),  64'd0);
        chk("rst_data",    64'(out_data), 64'd0);
        rst = 1'b0;
        tick();

        // Basic full frame, back-to-back, latency of one cycle
        out_rdy = 1'b1;
        push(16, 20, 4);
        send(1, 2, 0);
        send(3, 4, 0);
        send(5, 6, 0);
        chk("lat_before", 64'(out_val), 64'd0);
        send(7, 8, 0);
        chk("lat_after", 64'(out_val), 64'd1);
        chk("lat_in_rdy", 64'(in_rdy), 64'd0);
        tick();

        // Near-most-negative inputs must not wrap
        push(-524284, 0, 4);
        for (int i = 0; i < 4; i++) send(-131071, 0, 0);
        tick();

        // in_last ends a short frame; following frame counts from zero,
        // and in_last without in_val is ignored
        push(15, -5, 2);
        send(10, -10, 0);
        send(5, 5, 1);
        tick();
        push(10, 10, 4);
        send(1, 1, 0);
        in_last = 1'b1;
        tick();
        in_last = 1'b0;
        send(2, 2, 0);
        send(3, 3, 0);
        send(4, 4, 0);
        tick();

        // Back-pressure: result held stable, upstream stalled
        out_rdy = 1'b0;
        for (int i = 0; i < 4; i++) send(1, 0, 0);
        in_val  = 1'b1;
        in_data = {PW'(100), PW'(100)};
        for (int i = 0; i < 5; i++) begin
            chk("hold_in_rdy", 64'(in_rdy),   64'd0);
            chk("hold_data",   64'(out_data), 64'(pack(4, 0)));
            chk("hold_cnt",    64'(out_cnt),  64'd4);
            tick();
        end
        push(4, 0, 4);
        out_rdy = 1'b1;
        in_val  = 1'b0;
        tick();
        chk("release_in_rdy", 64'(in_rdy), 64'd1);
        push(7, 7, 1);
        send(7, 7, 1);
        tick();

        // Async reset mid-frame
        send(5, 5, 0);
        send(6, 6, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_val", 64'(out_val),  64'd0);
        chk("arst_in_rdy",  64'(in_rdy),   64'd1);
        chk("arst_cnt",     64'(out_cnt),  64'd0);
        chk("arst_data",    64'(out_data), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // sw_rst during OUT discards the pending result
        out_rdy = 1'b0;
        send(1, 2, 0);
        send(1, 2, 1);
        chk("pre_swrst_out_val", 64'(out_val), 64'd1);
        sw_rst = 1'b1;
        tick();
        sw_rst = 1'b0;
        chk("swrst_out_val", 64'(out_val),  64'd0);
        chk("swrst_in_rdy",  64'(in_rdy),   64'd1);
        chk("swrst_cnt",     64'(out_cnt),  64'd0);
        chk("swrst_data",    64'(out_data), 64'd0);

        // sw_rst beats a simultaneous sample acceptance
        in_val  = 1'b1;
        in_data = {PW'(50), PW'(50)};
        sw_rst  = 1'b1;
        tick();
        sw_rst  = 1'b0;
        in_val  = 1'b0;
        chk("swrst_acc_cnt", 64'(out_cnt), 64'd0);
        push(4, 4, 1);
        out_rdy = 1'b1;
        send(4, 4, 1);
        tick();

        // in_last on the 4th sample yields exactly one result
        push(4, 4, 4);
        send(1, 1, 0);
        send(1, 1, 0);
        send(1, 1, 0);
        send(1, 1, 1);
        repeat (4) tick();
        chk("single_result_out_val", 64'(out_val), 64'd0);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
